jelly_img_absdiff_stat: RTL
===========================

Name: jelly_img_absdiff_stat

Overview:
- Parametrised successor to the per-pixel absolute-difference stage: |data0-data1| per component, saturating component sum, and a per-pixel threshold mask.
- Accumulates per-frame statistics: total sum-of-differences and the count of over-threshold pixels.
- Reports frame statistics once per frame with a single-cycle strobe.
- Sits in the image pipeline after two aligned sources (frame/background, left/right), typically feeding motion detection.

Parameters:
- USER_WIDTH, 0, width of pass-through user sideband (USER_BITS = max(USER_WIDTH,1))
- COMPONENTS, 1, components per pixel
- DATA_WIDTH, 8, bits per component
- DATA_SIGNED, 0, 1 = components are two's complement; 0 = unsigned
- SUMDIFF_WIDTH, 10, width of per-pixel component sum (saturating)
- ACC_WIDTH, 32, width of frame sum accumulator (saturating)
- COUNT_WIDTH, 24, width of over-threshold pixel counter (saturating)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- cke  in  1  clock enable; all state advances only when cke=1
- param_threshold  in  SUMDIFF_WIDTH  mask threshold; sampled at frame start
- s_img_line_first / s_img_line_last / s_img_pixel_first / s_img_pixel_last / s_img_de  in  1 each  framing
- s_img_user  in  USER_BITS  sideband
- s_img_data0, s_img_data1  in  COMPONENTS*DATA_WIDTH  operands
- s_img_valid  in  1  pixel valid
- m_img_line_first / m_img_line_last / m_img_pixel_first / m_img_pixel_last / m_img_de  out  1 each  delayed framing
- m_img_user  out  USER_BITS  delayed sideband
- m_img_data0, m_img_data1  out  COMPONENTS*DATA_WIDTH  delayed operands
- m_img_diff  out  COMPONENTS*DATA_WIDTH  per-component absolute difference (unsigned)
- m_img_sumdiff  out  SUMDIFF_WIDTH  saturated component sum
- m_img_binary  out  1  sumdiff > active threshold
- m_img_valid  out  1  output valid
- m_frame_sum  out  ACC_WIDTH  sumdiff total of last completed frame
- m_frame_count  out  COUNT_WIDTH  over-threshold pixel count of last completed frame
- m_frame_valid  out  1  strobe: frame statistics updated

Behaviour:
- Reset: asynchronous. Every register and output clears to 0, including the active threshold, the accumulators and m_frame_valid.
- Pipeline: 3 cke-enabled stages, so latency is 3 cke cycles. Sideband and operands are delayed in lockstep with the data path.
- st0, absolute difference:
  - Unsigned mode: diff = larger - smaller.
  - Signed mode: compute a DATA_WIDTH+1 bit signed difference and take its magnitude. The result always fits DATA_WIDTH unsigned bits (max 2^DATA_WIDTH-1).
- st1, component sum: add all diffs at DATA_WIDTH+clog2(COMPONENTS) bits, then saturate to 2^SUMDIFF_WIDTH-1 if wider.
- st2, mask: binary = (sumdiff > thr_active), strictly greater.
- Qualifiers: frame start = valid & de & line_first & pixel_first. Frame end = valid & de & line_last & pixel_last. "Active pixel" = valid & de.
- Threshold sampling: when the frame-start pixel enters st0, param_threshold is copied to thr_active. That copy travels with the pipeline, so the frame-start pixel itself uses the new value. A change mid-frame has no effect until the next frame start.
- Accumulation at st2, for active pixels only:
  - Frame-start pixel: acc_sum loads sumdiff and acc_cnt loads binary; previous contents are discarded.
  - Other active pixels: acc_sum += sumdiff and acc_cnt += binary, both saturating at all-ones.
  - Inactive pixels (de=0 or valid=0) leave both accumulators unchanged.
- Frame report at st2:
  - On the frame-end pixel, m_frame_sum and m_frame_count are loaded with the accumulated values including that pixel, and m_frame_valid is set.
  - m_frame_valid clears on the next cke cycle.
- Boundary cases:
  - 1x1 frame (start and end on the same pixel): the report contains that pixel only.
  - Start without a preceding end: accumulators restart and no report is issued.
  - End without any start since reset: report whatever has accumulated from 0.
  - cke=0: everything holds, including m_frame_valid.
  - Reset mid-frame: no report; the first frame start after reset begins a fresh accumulation.

Decomposition:
- Shared package constants:
  - function clog2
  - saturating-add helper
  - frame-start/frame-end qualifier expressions
- One sub-module: jelly_img_absdiff_stat_calc, the combinational per-component abs diff (signed/unsigned) plus saturating sum. The pipeline, threshold latch and accumulators stay in the top.

Test Plan:
- Latency (COMPONENTS=3, DATA_WIDTH=8, unsigned): data0={10,200,5}, data1={30,100,5}, one valid pixel -> three cke cycles later diff={20,100,0}, sumdiff=120, valid=1.
- Saturation (SUMDIFF_WIDTH=8): data0={255,255,255}, data1={0,0,0} -> sumdiff=255, not 765 mod 256. Signed mode, DATA_WIDTH=8: data0=-128, data1=127 -> diff=255.
- Threshold latch: threshold=50 at frame start, changed to 10 mid-frame; pixel sumdiffs 40, 60, 20 in a 3x1 frame -> binary 0,1,0. Report count=1, sum=120, m_frame_valid high for exactly one cke cycle.
- Gaps and cke: the same 3x1 frame with de=0 bubbles and random cke=0 cycles inserted -> identical report. Bubble pixels do not count. Output timing stretches only by the cke stalls.
- Framing: 1x1 frame sumdiff=7, threshold 0 -> sum=7, count=1. Two starts before one end: the report covers only pixels from the second start.
- Reset: assert reset mid-frame -> all outputs 0 immediately (asynchronous). No m_frame_valid until a complete new frame; that frame's stats exclude pre-reset pixels.

Source files
------------

// File: rtl/jelly_img_absdiff_stat_pkg.sv
// Shared types and helpers for the absolute-difference statistics stage:
// framing flags, clog2, saturating add and frame qualifiers.
package jelly_img_absdiff_stat_pkg;

    typedef struct packed {
        logic line_first;
        logic line_last;
        logic pixel_first;
        logic pixel_last;
        logic de;
        logic valid;
    } img_flags_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Add two values and clamp to the all-ones value of a width-bit field.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned width);
        logic [64:0] sum;
        logic [64:0] lim;
        lim = (65'd1 << width) - 65'd1;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

    function automatic logic is_active(input img_flags_t f);
        return f.valid & f.de;
    endfunction

    function automatic logic is_frame_start(input img_flags_t f);
        return f.valid & f.de & f.line_first & f.pixel_first;
    endfunction

    function automatic logic is_frame_end(input img_flags_t f);
        return f.valid & f.de & f.line_last & f.pixel_last;
    endfunction

endpackage

// File: rtl/jelly_img_absdiff_stat_calc.sv
// Combinational helpers: per-component absolute difference and the
// saturating sum of a set of component differences.
module jelly_img_absdiff_stat_calc
    import jelly_img_absdiff_stat_pkg::*;
#(
    parameter int unsigned COMPONENTS    = 1,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned DATA_SIGNED   = 0,
    parameter int unsigned SUMDIFF_WIDTH = 10
)(
    input  logic [COMPONENTS*DATA_WIDTH-1:0] data0_i,
    input  logic [COMPONENTS*DATA_WIDTH-1:0] data1_i,
    output logic [COMPONENTS*DATA_WIDTH-1:0] diff_c_o,
    input  logic [COMPONENTS*DATA_WIDTH-1:0] diff_i,
    output logic [SUMDIFF_WIDTH-1:0]         sumdiff_c_o
);

    localparam int unsigned EXT_W = DATA_WIDTH + 1;
    localparam int unsigned SUM_W = DATA_WIDTH + clog2(COMPONENTS);

    // A DATA_WIDTH+1 bit difference always holds the true result, so its
    // magnitude fits DATA_WIDTH unsigned bits in both modes.
    function automatic logic [DATA_WIDTH-1:0] abs_diff(input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
        logic [EXT_W-1:0] d;
        if (DATA_SIGNED != 0) begin
            d = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
        end else begin
            d = {1'b0, a} - {1'b0, b};
        end
        return DATA_WIDTH'(d[DATA_WIDTH] ? (~d + EXT_W'(1)) : d);
    endfunction

    logic [SUM_W-1:0] sum_c;

    always_comb begin
        diff_c_o = '0;
        for (int unsigned c = 0; c < COMPONENTS; c++) begin
            diff_c_o[c*DATA_WIDTH +: DATA_WIDTH] =
                abs_diff(data0_i[c*DATA_WIDTH +: DATA_WIDTH], data1_i[c*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    always_comb begin
        sum_c = '0;
        for (int unsigned c = 0; c < COMPONENTS; c++) begin
            sum_c = sum_c + SUM_W'(diff_i[c*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    generate
        if (SUM_W > SUMDIFF_WIDTH) begin : g_sat
            assign sumdiff_c_o = (sum_c[SUM_W-1:SUMDIFF_WIDTH] != '0) ? '1
                                                                       : sum_c[SUMDIFF_WIDTH-1:0];
        end else begin : g_ext
            assign sumdiff_c_o = SUMDIFF_WIDTH'(sum_c);
        end
    endgenerate

endmodule

// File: rtl/jelly_img_absdiff_stat.sv
// Three-stage absolute-difference pipeline with threshold mask and
// per-frame sum / over-threshold count reporting.
module jelly_img_absdiff_stat
    import jelly_img_absdiff_stat_pkg::*;
#(
    parameter  int unsigned USER_WIDTH    = 0,
    parameter  int unsigned COMPONENTS    = 1,
    parameter  int unsigned DATA_WIDTH    = 8,
    parameter  int unsigned DATA_SIGNED   = 0,
    parameter  int unsigned SUMDIFF_WIDTH = 10,
    parameter  int unsigned ACC_WIDTH     = 32,
    parameter  int unsigned COUNT_WIDTH   = 24,
    localparam int unsigned USER_BITS     = (USER_WIDTH > 0) ? USER_WIDTH : 1,
    localparam int unsigned DATA_BITS     = COMPONENTS * DATA_WIDTH
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cke,
    input  logic [SUMDIFF_WIDTH-1:0] param_threshold,

    input  logic                     s_img_line_first,
    input  logic                     s_img_line_last,
    input  logic                     s_img_pixel_first,
    input  logic                     s_img_pixel_last,
    input  logic                     s_img_de,
    input  logic [USER_BITS-1:0]     s_img_user,
    input  logic [DATA_BITS-1:0]     s_img_data0,
    input  logic [DATA_BITS-1:0]     s_img_data1,
    input  logic                     s_img_valid,

    output logic                     m_img_line_first,
    output logic                     m_img_line_last,
    output logic                     m_img_pixel_first,
    output logic                     m_img_pixel_last,
    output logic                     m_img_de,
    output logic [USER_BITS-1:0]     m_img_user,
    output logic [DATA_BITS-1:0]     m_img_data0,
    output logic [DATA_BITS-1:0]     m_img_data1,
    output logic [DATA_BITS-1:0]     m_img_diff,
    output logic [SUMDIFF_WIDTH-1:0] m_img_sumdiff,
    output logic                     m_img_binary,
    output logic                     m_img_valid,

    output logic [ACC_WIDTH-1:0]     m_frame_sum,
    output logic [COUNT_WIDTH-1:0]   m_frame_count,
    output logic                     m_frame_valid
);

    img_flags_t               s_flags;
    img_flags_t               st0_flags_q, st1_flags_q, st2_flags_q;
    logic [USER_BITS-1:0]     st0_user_q, st1_user_q, st2_user_q;
    logic [DATA_BITS-1:0]     st0_data0_q, st1_data0_q, st2_data0_q;
    logic [DATA_BITS-1:0]     st0_data1_q, st1_data1_q, st2_data1_q;
    logic [DATA_BITS-1:0]     st0_diff_q, st1_diff_q, st2_diff_q;
    logic [SUMDIFF_WIDTH-1:0] st1_sum_q, st2_sum_q;
    logic [SUMDIFF_WIDTH-1:0] thr0_q, thr1_q, thr0_d;
    logic                     binary_q, binary_d;
    logic [ACC_WIDTH-1:0]     acc_sum_q, acc_sum_d, frame_sum_q, frame_sum_d;
    logic [COUNT_WIDTH-1:0]   acc_cnt_q, acc_cnt_d, frame_cnt_q, frame_cnt_d;
    logic                     frame_valid_q, frame_valid_d;
    logic [DATA_BITS-1:0]     diff_c;
    logic [SUMDIFF_WIDTH-1:0] sumdiff_c;

    assign s_flags = '{line_first: s_img_line_first, line_last: s_img_line_last,
                       pixel_first: s_img_pixel_first, pixel_last: s_img_pixel_last,
                       de: s_img_de, valid: s_img_valid};

    jelly_img_absdiff_stat_calc #(
        .COMPONENTS    (COMPONENTS),
        .DATA_WIDTH    (DATA_WIDTH),
        .DATA_SIGNED   (DATA_SIGNED),
        .SUMDIFF_WIDTH (SUMDIFF_WIDTH)
    ) u_calc (
        .data0_i     (s_img_data0),
        .data1_i     (s_img_data1),
        .diff_c_o    (diff_c),
        .diff_i      (st0_diff_q),
        .sumdiff_c_o (sumdiff_c)
    );

    // Threshold is latched by the frame-start pixel and rides with the data.
    always_comb begin
        thr0_d        = thr0_q;
        binary_d      = (st1_sum_q > thr1_q);
        acc_sum_d     = acc_sum_q;
        acc_cnt_d     = acc_cnt_q;
        frame_sum_d   = frame_sum_q;
        frame_cnt_d   = frame_cnt_q;
        frame_valid_d = 1'b0;
        if (is_frame_start(s_flags)) begin
            thr0_d = param_threshold;
        end
        if (is_frame_start(st1_flags_q)) begin
            acc_sum_d = ACC_WIDTH'(st1_sum_q);
            acc_cnt_d = COUNT_WIDTH'(binary_d);
        end else if (is_active(st1_flags_q)) begin
            acc_sum_d = ACC_WIDTH'(sat_add(64'(acc_sum_q), 64'(st1_sum_q), ACC_WIDTH));
            acc_cnt_d = COUNT_WIDTH'(sat_add(64'(acc_cnt_q), 64'(binary_d), COUNT_WIDTH));
        end
        if (is_frame_end(st1_flags_q)) begin
            frame_sum_d   = acc_sum_d;
            frame_cnt_d   = acc_cnt_d;
            frame_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st0_flags_q   <= '0;
            st1_flags_q   <= '0;
            st2_flags_q   <= '0;
            st0_user_q    <= '0;
            st1_user_q    <= '0;
            st2_user_q    <= '0;
            st0_data0_q   <= '0;
            st1_data0_q   <= '0;
            st2_data0_q   <= '0;
            st0_data1_q   <= '0;
            st1_data1_q   <= '0;
            st2_data1_q   <= '0;
            st0_diff_q    <= '0;
            st1_diff_q    <= '0;
            st2_diff_q    <= '0;
            st1_sum_q     <= '0;
            st2_sum_q     <= '0;
            thr0_q        <= '0;
            thr1_q        <= '0;
            binary_q      <= 1'b0;
            acc_sum_q     <= '0;
            acc_cnt_q     <= '0;
            frame_sum_q   <= '0;
            frame_cnt_q   <= '0;
            frame_valid_q <= 1'b0;
        end else if (cke) begin
            st0_flags_q   <= s_flags;
            st1_flags_q   <= st0_flags_q;
            st2_flags_q   <= st1_flags_q;
            st0_user_q    <= s_img_user;
            st1_user_q    <= st0_user_q;
            st2_user_q    <= st1_user_q;
            st0_data0_q   <= s_img_data0;
            st1_data0_q   <= st0_data0_q;
            st2_data0_q   <= st1_data0_q;
            st0_data1_q   <= s_img_data1;
            st1_data1_q   <= st0_data1_q;
            st2_data1_q   <= st1_data1_q;
            st0_diff_q    <= diff_c;
            st1_diff_q    <= st0_diff_q;
            st2_diff_q    <= st1_diff_q;
            st1_sum_q     <= sumdiff_c;
            st2_sum_q     <= st1_sum_q;
            thr0_q        <= thr0_d;
            thr1_q        <= thr0_q;
            binary_q      <= binary_d;
            acc_sum_q     <= acc_sum_d;
            acc_cnt_q     <= acc_cnt_d;
            frame_sum_q   <= frame_sum_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign m_img_line_first  = st2_flags_q.line_first;
    assign m_img_line_last   = st2_flags_q.line_last;
    assign m_img_pixel_first = st2_flags_q.pixel_first;
    assign m_img_pixel_last  = st2_flags_q.pixel_last;
    assign m_img_de          = st2_flags_q.de;
    assign m_img_valid       = st2_flags_q.valid;
    assign m_img_user        = st2_user_q;
    assign m_img_data0       = st2_data0_q;
    assign m_img_data1       = st2_data1_q;
    assign m_img_diff        = st2_diff_q;
    assign m_img_sumdiff     = st2_sum_q;
    assign m_img_binary      = binary_q;
    assign m_frame_sum       = frame_sum_q;
    assign m_frame_count     = frame_cnt_q;
    assign m_frame_valid     = frame_valid_q;

endmodule
